// File: rtl/f_fetch_stage_if.sv
// Instruction-memory port and F-side outputs feeding the F/D pipeline register.
// The master modport belongs to the fetch stage. The slave modport belongs to the memory and F/D side.
interface f_fetch_stage_if;
    logic [31:0] i_inst_addr;
    logic [31:0] i_inst_rdata;
    logic [31:0] instr_F;
    logic [31:0] PC_F;
    logic [4:0]  F_excCode;
    logic        bd_F;

    modport master (
        output i_inst_addr,
        output instr_F,
        output PC_F,
        output F_excCode,
        output bd_F,
        input  i_inst_rdata
    );

    modport slave (
        input  i_inst_addr,
        input  instr_F,
        input  PC_F,
        input  F_excCode,
        input  bd_F,
        output i_inst_rdata
    );
endinterface

// File: rtl/f_fetch_stage.sv
// Fetch stage that owns the architectural PC and selects the next fetch address.
// It also flags fetch address errors and squashes the word that follows an eret.
module f_fetch_stage #(
    parameter logic [31:0] PC_RESET   = 32'h0000_3000,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter logic [31:0] IM_LO      = 32'h0000_3000,
    parameter logic [31:0] IM_HI      = 32'h0000_6FFC,
    parameter logic [4:0]  EXC_ADEL   = 5'd4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            F_en,
    input  logic            req,
    input  logic            D_eret,
    input  logic [31:0]     EPC,
    input  logic            D_jump,
    input  logic            D_taken,
    input  logic [31:0]     D_target,
    f_fetch_stage_if.master fif
);

    typedef enum logic [2:0] {
        SRC_HANDLER,
        SRC_EPC,
        SRC_HOLD,
        SRC_TARGET,
        SRC_SEQ
    } pc_src_e;

    logic [31:0] pc_r;
    logic [31:0] pc_next;
    logic        eret_pend;
    logic        eret_pend_next;
    pc_src_e     pc_src;
    logic        adel;
    logic        squash;

    // The order of these checks is the next-PC priority. A CP0 flush overrides a stall.
    always_comb begin
        if (req)                pc_src = SRC_HANDLER;
        else if (D_eret && F_en) pc_src = SRC_EPC;
        else if (!F_en)         pc_src = SRC_HOLD;
        else if (D_taken)       pc_src = SRC_TARGET;
        else                    pc_src = SRC_SEQ;
    end

    always_comb begin
        // NOTE: both outputs get a default first, so no path through this block can infer a latch.
        pc_next        = pc_r + 32'd4;
        eret_pend_next = 1'b0;
        unique case (pc_src)
            SRC_HANDLER: pc_next = HANDLER_PC;
            SRC_EPC:     pc_next = EPC;
            SRC_HOLD: begin
                pc_next        = pc_r;
                eret_pend_next = D_eret;
            end
            SRC_TARGET:  pc_next = D_target;
            SRC_SEQ:     pc_next = pc_r + 32'd4;
            default:     pc_next = pc_r + 32'd4;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples values from before the edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_r      <= PC_RESET;
            eret_pend <= 1'b0;
        end else begin
            pc_r      <= pc_next;
            eret_pend <= eret_pend_next;
        end
    end

    assign adel   = (pc_r[1:0] != 2'b00) || (pc_r < IM_LO) || (pc_r > IM_HI);
    // The word behind an eret is never issued. That includes any exception it would raise.
    assign squash = D_eret || eret_pend;

    always_comb begin
        fif.i_inst_addr = pc_r;
        fif.PC_F        = pc_r;
        fif.instr_F     = (squash || adel) ? 32'h0 : fif.i_inst_rdata;
        fif.F_excCode   = (!squash && adel) ? EXC_ADEL : 5'd0;
        fif.bd_F        = D_jump && !D_eret && !eret_pend;
    end

endmodule

// File: doc/f_fetch_stage.md
Name: f_fetch_stage

Overview:
- Fetch-stage producer that owns the architectural PC and drives the F-side inputs of the F/D pipeline register: instruction, PC, exception code and branch-delay flag.
- Sequences the PC through sequential fetch, branch/jump redirect, stall hold, eret return and interrupt/exception entry at 0x0000_4180.
- Detects fetch address errors (AdEL) and squashes the fetched word when the fetch is invalid.
- Sits between the instruction-memory port and the F/D register, on the opposite side of that register from decode.

Parameters:
- PC_RESET, 32'h0000_3000, PC value after reset.
- HANDLER_PC, 32'h0000_4180, PC loaded on req.
- IM_LO, 32'h0000_3000, lowest legal fetch address.
- IM_HI, 32'h0000_6FFC, highest legal fetch address.
- EXC_ADEL, 5'd4, exception code reported for a bad fetch.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- F_en  input  1  PC advance enable; 0 = stall (same signal as D_en of the F/D register).
- req  input  1  exception/interrupt flush from CP0; overrides everything.
- D_eret  input  1  instruction in D is eret.
- EPC  input  32  return address from CP0.
- D_jump  input  1  instruction in D is a branch/jump, taken or not. The next fetched instruction is its delay slot.
- D_taken  input  1  branch/jump in D redirects.
- D_target  input  32  redirect target computed in D.
- i_inst_rdata  input  32  instruction word returned for i_inst_addr; combinational memory.
- i_inst_addr  output  32  fetch address; always equals PC_F.
- instr_F  output  32  fetched instruction, or 0 when squashed.
- PC_F  output  32  current fetch PC.
- F_excCode  output  5  EXC_ADEL or 0.
- bd_F  output  1  fetched instruction is a delay slot.

Behaviour:
- Single state register pc_r (32 bits) plus one-bit eret_pend register; PC_F = i_inst_addr = pc_r.
- Reset (reset=0, asynchronous): pc_r = PC_RESET, eret_pend = 0. All outputs settle combinationally from these values:
  - instr_F = i_inst_rdata at 0x3000.
  - F_excCode = 0, bd_F = 0.
- Next-PC priority, evaluated at posedge clk when reset=1:
  1. req=1: pc_r <= HANDLER_PC, eret_pend <= 0. Applies even if F_en=0.
  2. D_eret=1 and F_en=1: pc_r <= EPC. No delay slot.
  3. F_en=0: pc_r held; eret_pend <= D_eret.
  4. D_taken=1: pc_r <= D_target.
  5. Otherwise: pc_r <= pc_r + 4, 32-bit wrap; wrap is not reachable in legal code.
- eret squash: when D_eret=1 or eret_pend=1, instr_F = 0, F_excCode = 0 and bd_F = 0. The word behind an eret is never issued.
  - eret_pend clears on the first cycle F_en=1 or req=1.
- AdEL: raised when pc_r[1:0] != 0, pc_r < IM_LO, or pc_r > IM_HI (unsigned compares).
  - Result: F_excCode = EXC_ADEL and instr_F = 0 (converted to nop). PC_F still reports the bad PC so CP0 can load it into EPC/BadVAddr.
  - The PC keeps advancing normally until req arrives.
- bd_F = D_jump & ~D_eret & ~eret_pend. It is independent of D_taken, so a not-taken branch still marks its slot.
- AdEL and bd_F may be asserted together; both are forwarded.
- Simultaneous req and D_eret: req wins, pc_r = HANDLER_PC.
- Stall with a pending redirect: D holds its instruction, so D_taken/D_target are re-presented and applied on the first cycle F_en=1.
- Reset mid-stall or mid-redirect: everything returns to the reset state immediately.

Test Plan:
- Reset release, F_en=1, no control: PC_F sequence is 0x3000, 0x3004, 0x3008. F_excCode=0 and bd_F=0 throughout.
- D_jump=1, D_taken=1, D_target=0x3100 while PC_F=0x3008:
  - That cycle: bd_F=1.
  - Next cycle: PC_F=0x3100, bd_F=0.
  - Repeat with D_taken=0: PC_F=0x300C and bd_F still 1 on the slot cycle.
- F_en=0 for 3 cycles at PC_F=0x3010 with D_taken=1, D_target=0x3200:
  - PC_F holds 0x3010.
  - First cycle after F_en=1: PC_F=0x3200.
- D_target=0x3002 taken: PC_F=0x3002, F_excCode=4, instr_F=0. Assert req next cycle: PC_F=0x4180, F_excCode=0.
- D_target=0x7000 taken: F_excCode=4. Also verify that PC_F=0x6FFC gives F_excCode=0.
- eret cases:
  - D_eret=1 with EPC=0x3044: instr_F=0 that cycle, next PC_F=0x3044.
  - D_eret=1 with F_en=0 for 2 cycles: instr_F stays 0 while stalled, then PC_F=0x3044.
  - req and D_eret asserted in the same cycle: PC_F=0x4180.
